// File: rtl/cube_frame_sched_if.sv
// cube_frame_sched_if: control, raster-channel and shared-DMA signals of the frame scheduler
interface cube_frame_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = 2
);
    logic           go;
    logic           clr_overrun;
    logic [NCH-1:0] chan_drq;
    logic [NCH-1:0] chan_finished;
    logic           dma_nrq;
    logic [NCH-1:0] chan_enable;
    logic [NCH-1:0] chan_ack;
    logic           dma_drq;
    logic           dma_grant_valid;
    logic [CW-1:0]  dma_grant_ch;
    logic           frame_done;
    logic           busy;
    logic           overrun;
    modport master (
        input  go, clr_overrun, chan_drq, chan_finished, dma_nrq,
        output chan_enable, chan_ack, dma_drq, dma_grant_valid, dma_grant_ch, frame_done, busy, overrun
    );
    modport slave (
        output go, clr_overrun, chan_drq, chan_finished, dma_nrq,
        input  chan_enable, chan_ack, dma_drq, dma_grant_valid, dma_grant_ch, frame_done, busy, overrun
    );
endinterface

// File: rtl/cube_frame_sched.sv
// cube_frame_sched: frame tick, start/collect/ack sequencing of raster channels, round-robin DMA arbiter
module cube_frame_sched #(
    parameter int NCH       = 4,
    parameter int CW        = 2,
    parameter int FRAME_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    cube_frame_sched_if.master bus
);
    localparam int TW = $clog2(FRAME_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(FRAME_DIV - 1);
    typedef enum logic [1:0] {IDLE, START, RUN, ACK} state_t;
    state_t         state, state_nx;
    logic [TW-1:0]  cnt;
    logic           tick;
    logic [NCH-1:0] done_mask, seen;
    logic [CW-1:0]  rr_ptr, win, idx, grant_ch;
    logic           grant_valid, overrun_q;
    assign tick = bus.go && cnt == '0;
    assign seen = done_mask | bus.chan_finished;
    // frame timer: held at reload while stopped, counts down and reloads on tick
    always_ff @(posedge clk)
        cnt <= (reset || !bus.go || cnt == '0) ? RELOAD : cnt - 1'b1;
    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // next state: start on tick, wait for every channel, ack once, back to idle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tick ? START : IDLE;
            START:   state_nx = RUN;
            RUN:     state_nx = &seen ? ACK : RUN;
            default: state_nx = IDLE;
        endcase
    end
    // outputs decoded from state so enable/ack are single-cycle pulses
    always_comb begin
        bus.chan_enable = {NCH{state == START}};
        bus.chan_ack    = {NCH{state == ACK}};
        bus.frame_done  = state == ACK;
        bus.busy        = state != IDLE;
    end
    // finished flags latched only during RUN; cleared at START so stale flags are ignored
    always_ff @(posedge clk)
        done_mask <= (reset || state == START) ? '0 : state == RUN ? seen : done_mask;
    // sticky overrun: a tick while a frame is open; setting beats clearing
    always_ff @(posedge clk)
        overrun_q <= reset ? 1'b0 : (tick && state != IDLE) ? 1'b1 : bus.clr_overrun ? 1'b0 : overrun_q;
    // first requester at or after rr_ptr; walking downward leaves the nearest one in win
    always_comb begin
        win = rr_ptr;
        idx = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % NCH);
            win = bus.chan_drq[idx] ? idx : win;
        end
    end
    // grant held until burst complete; release edge never grants, forcing an idle cycle
    always_ff @(posedge clk)
        if (reset) begin
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            rr_ptr      <= '0;
        end else if (grant_valid) begin
            grant_valid <= !bus.dma_nrq;
        end else if (|bus.chan_drq) begin
            grant_valid <= 1'b1;
            grant_ch    <= win;
            rr_ptr      <= (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
        end
    assign bus.dma_drq         = grant_valid & bus.chan_drq[grant_ch];
    assign bus.dma_grant_valid = grant_valid;
    assign bus.dma_grant_ch    = grant_ch;
    assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_cube_frame_sched.sv
// tb_cube_frame_sched: random stimulus, frame/arbiter reference model feeding a scoreboard queue
module tb_cube_frame_sched;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int FD  = 10;
    localparam logic [NCH-1:0] ALL = '1;
    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] ack;
        logic           done;
        logic           busy;
        logic           ovr;
        logic           gv;
        logic [CW-1:0]  och;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    cube_frame_sched_if #(.NCH(NCH), .CW(CW)) bus();
    cube_frame_sched #(.NCH(NCH), .CW(CW), .FRAME_DIV(FD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // reference model: frame phases as flags, timer as a run length, arbiter as "next after last winner"
    bit             starting, running, acking, ovr, tick, was_busy, found;
    bit [NCH-1:0]   got;
    int             go_run, owner, last, nxt;
    initial begin
        owner = -1;
        last = NCH - 1;
    end
    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            starting = 0; running = 0; acking = 0; ovr = 0; got = '0;
            go_run = 0; owner = -1; last = NCH - 1;
        end else begin
            tick = bus.go && (go_run % FD == FD - 1);
            go_run = bus.go ? go_run + 1 : 0;
            was_busy = starting || running || acking;
            if (tick && was_busy) ovr = 1;
            else if (bus.clr_overrun) ovr = 0;
            if (acking) acking = 0;
            else if (running) begin
                got |= bus.chan_finished;
                if (got == ALL) begin running = 0; acking = 1; end
            end else if (starting) begin
                starting = 0; running = 1; got = '0;
            end else if (tick) starting = 1;
            if (owner >= 0) begin
                if (bus.dma_nrq) owner = -1;
            end else if (bus.chan_drq != '0) begin
                found = 0;
                nxt = 0;
                for (int k = 1; k <= NCH; k++)
                    if (!found && bus.chan_drq[CW'((last + k) % NCH)]) begin
                        found = 1;
                        nxt = (last + k) % NCH;
                    end
                owner = nxt;
                last = nxt;
            end
        end
        e.en   = starting ? ALL : '0;
        e.ack  = acking ? ALL : '0;
        e.done = acking;
        e.busy = starting || running || acking;
        e.ovr  = ovr;
        e.gv   = owner >= 0;
        e.och  = CW'(owner < 0 ? 0 : owner);
        sb.push_back(e);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask
    // monitor: pop the expected response for the cycle the DUT is presenting
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
        end else begin
            e = sb.pop_front();
            chk("chan_enable", 32'(bus.chan_enable), 32'(e.en));
            chk("chan_ack", 32'(bus.chan_ack), 32'(e.ack));
            chk("frame_done", 32'(bus.frame_done), 32'(e.done));
            chk("busy", 32'(bus.busy), 32'(e.busy));
            chk("overrun", 32'(bus.overrun), 32'(e.ovr));
            chk("dma_grant_valid", 32'(bus.dma_grant_valid), 32'(e.gv));
            chk("dma_drq", 32'(bus.dma_drq), 32'(e.gv ? bus.chan_drq[e.och] : 1'b0));
            if (e.gv) chk("dma_grant_ch", 32'(bus.dma_grant_ch), 32'(e.och));
        end
    end
    // stimulus: phased random traffic, inputs changed shortly after each rising edge
    initial begin
        bus.go = 0; bus.clr_overrun = 0; bus.chan_drq = '0; bus.chan_finished = '0; bus.dma_nrq = 0;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk);
            #2;
            reset = 0;
            bus.clr_overrun = 0;
            for (int b = 0; b < NCH; b++) bus.chan_finished[b] = ($urandom_range(3) == 0);
            bus.chan_drq = NCH'($urandom);
            bus.dma_nrq = ($urandom_range(2) == 0);
            if (c < 150) begin
                bus.go = 1;
            end else if (c < 300) begin
                bus.go = 1;
                bus.chan_finished[1] = 0;
                bus.clr_overrun = (c == 250);
            end else if (c < 450) begin
                bus.go = 1;
                bus.chan_drq = ALL;
                bus.dma_nrq = ($urandom_range(3) == 0);
                bus.clr_overrun = (c == 320);
            end else begin
                if ($urandom_range(49) == 0) bus.go = ~bus.go;
                bus.clr_overrun = ($urandom_range(29) == 0);
                reset = ($urandom_range(79) == 0);
                if ($urandom_range(1) == 0) bus.chan_finished = ALL;
            end
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
